// File: rtl/button_event_decoder.sv
// Classifies debounced button gestures into single, long and double-click event pulses.
// Optional build macro AUTO_REPEAT_EN enables periodic repeat pulses while a long press is held.
module button_event_decoder #(
  parameter int CNT_W         = 16,
  parameter int LONG_CYCLES   = 50000,
  parameter int DCLICK_CYCLES = 20000,
  parameter int REPEAT_CYCLES = 10000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic press_pulse,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic held,
  output logic repeat_pulse
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESSED      = 3'd1,
    WAIT_SECOND  = 3'd2,
    SECOND_PRESS = 3'd3,
    LONG_HELD    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LONG_M1   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DCLICK_M1 = CNT_W'(DCLICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_M1 = CNT_W'(REPEAT_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             level_q;
  logic             rise, fall;
  logic             press_nx, short_nx, long_nx, dbl_nx, rep_nx;
  logic             cnt_clr, cnt_hold;

  assign rise = level & ~level_q;
  assign fall = ~level & level_q;

  always_comb begin
    state_nx = state;
    press_nx = 1'b0;
    short_nx = 1'b0;
    long_nx  = 1'b0;
    dbl_nx   = 1'b0;
    rep_nx   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_hold = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nx = PRESSED;
          press_nx = 1'b1;
        end
      end
      PRESSED: begin
        if (fall) begin
          state_nx = WAIT_SECOND;
        end else if (cnt == LONG_M1) begin
          state_nx = LONG_HELD;
          long_nx  = 1'b1;
        end
      end
      WAIT_SECOND: begin
        // A second press on the timeout edge still counts as a double click.
        if (rise) begin
          state_nx = SECOND_PRESS;
          press_nx = 1'b1;
        end else if (cnt == DCLICK_M1) begin
          state_nx = IDLE;
          short_nx = 1'b1;
        end
      end
      SECOND_PRESS: begin
        if (fall) begin
          state_nx = IDLE;
          dbl_nx   = 1'b1;
        end else if (cnt == LONG_M1) begin
          state_nx = LONG_HELD;
          short_nx = 1'b1;
          long_nx  = 1'b1;
        end
      end
      LONG_HELD: begin
        if (fall) state_nx = IDLE;
        // Repeat timing is independent of release, so a repeat may coincide with the release edge.
        if (!REPEAT_ON) begin
          cnt_hold = 1'b1;
        end else if (cnt == REPEAT_M1) begin
          rep_nx  = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cnt_nx = cnt;
    if (state_nx != state || cnt_clr) cnt_nx = '0;
    else if (!cnt_hold && !(&cnt))    cnt_nx = cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      level_q      <= 1'b1;
      press_pulse  <= 1'b0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
      held         <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      level_q      <= level;
      press_pulse  <= press_nx;
      short_press  <= short_nx;
      long_press   <= long_nx;
      double_click <= dbl_nx;
      held         <= (state_nx == LONG_HELD);
      repeat_pulse <= rep_nx;
    end
  end

endmodule
